// File: rtl/elm_neuron_mac_lanes.sv
// ELM hidden-layer neuron, LANES-wide MAC with ready/valid on both sides.
// act(sum(x*w) + b) with saturation and run-time activation select.
module elm_neuron_mac_lanes #(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int DW         = 16,
    parameter int FW         = 8,
    parameter int NUM_WEIGHT = 128,
    parameter int LANES      = 4,
    parameter int CFGW       = 2*DW+1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFGW-1:0]       cfg_layer,
    input  logic [CFGW-1:0]       cfg_neuron,
    input  logic                  wt_valid,
    input  logic [DW-1:0]         wt_data,
    input  logic                  bias_valid,
    input  logic [DW-1:0]         bias_data,
    input  logic [1:0]            act_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic                  out_sat
);

    localparam int BEATS = NUM_WEIGHT / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int ACCW  = 2*DW + $clog2(NUM_WEIGHT) + 1;
    localparam int SW    = ACCW + 1;

    localparam logic signed [SW-1:0] SMAX = SW'((2**(DW-1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
    localparam logic signed [SW-1:0] ONE  = SW'(2**FW);
    localparam logic signed [SW-1:0] HALF = SW'(2**(FW-1));

    typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

    state_t state, state_nx;

    logic [BW-1:0] beat_cnt;
    logic [IW-1:0] wptr;
    logic [DW-1:0] wram [NUM_WEIGHT];
    logic [1:0]    mode_q;
    logic          id_match, idle, take, first, last, wr_en;
    logic          v1, l1, v2, l2, l3;

    logic signed [DW-1:0]   x_q    [LANES];
    logic signed [DW-1:0]   w_q    [LANES];
    logic signed [2*DW-1:0] prod_q [LANES];
    logic signed [ACCW-1:0] tree_sum, acc, bias_q;
    logic signed [SW-1:0]   s_w, r_w, h_w, v_w;
    logic                   sat_d;

    assign id_match = (cfg_layer == CFGW'(LAYER_NO))
                   && (cfg_neuron == CFGW'(NEURON_NO));
    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign take      = in_valid && in_ready;
    assign first     = take && (beat_cnt == '0);
    assign last      = take && (beat_cnt == BW'(BEATS-1));
    assign idle      = (state == ACC) && (beat_cnt == '0);
    assign wr_en     = wt_valid && id_match && idle;

    // weight RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en)
            wram[wptr] <= wt_data;
    end

    // config registers: write pointer, bias, sampled activation mode
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            bias_q <= '0;
            mode_q <= '0;
        end else begin
            if (wr_en)
                wptr <= (wptr == IW'(NUM_WEIGHT-1)) ? '0 : wptr + IW'(1);
            if (bias_valid && id_match && idle)
                bias_q <= ACCW'($signed(bias_data)) <<< FW;
            if (first)
                mode_q <= act_mode;
        end
    end

    // beat counter, wraps after the final beat of a vector
    always_ff @(posedge clk) begin
        if (rst)
            beat_cnt <= '0;
        else if (take)
            beat_cnt <= last ? '0 : beat_cnt + BW'(1);
    end

    // stage 1 operands and stage 2 products (datapath, no reset needed)
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (take) begin
                x_q[k] <= in_data[k*DW +: DW];
                w_q[k] <= wram[IW'(int'(beat_cnt)*LANES + k)];
            end
            if (v1)
                prod_q[k] <= (2*DW)'(x_q[k]) * (2*DW)'(w_q[k]);
        end
    end

    // valid/last tokens travelling alongside the datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            v2 <= 1'b0;
            l2 <= 1'b0;
            l3 <= 1'b0;
        end else begin
            v1 <= take;
            l1 <= last;
            v2 <= v1;
            l2 <= l1;
            l3 <= v2 && l2;
        end
    end

    // lane adder tree
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++)
            tree_sum = tree_sum + ACCW'(prod_q[k]);
    end

    // accumulator, cleared once the result has been taken
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (out_valid && out_ready)
            acc <= '0;
        else if (v2)
            acc <= acc + tree_sum;
    end

    // bias add, rescale, activation and output saturation
    always_comb begin
        s_w   = SW'(acc) + SW'(bias_q);
        r_w   = s_w >>> FW;
        h_w   = (r_w >>> 2) + HALF;
        v_w   = r_w;
        sat_d = 1'b0;
        unique case (1'b1)
            (mode_q == 2'd1): begin
                if (r_w[SW-1])
                    v_w = '0;
            end
            (mode_q == 2'd2): begin
                if (h_w[SW-1])
                    v_w = '0;
                else if (h_w > ONE)
                    v_w = ONE;
                else
                    v_w = h_w;
            end
            default: ;
        endcase
        if (mode_q != 2'd2) begin
            if (v_w > SMAX) begin
                v_w   = SMAX;
                sat_d = 1'b1;
            end else if (v_w < SMIN) begin
                v_w   = SMIN;
                sat_d = 1'b1;
            end
        end
    end

    // result register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (l3) begin
            out_data <= v_w[DW-1:0];
            out_sat  <= sat_d;
        end
    end

    // control state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ACC;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ACC:     if (last) state_nx = DRAIN;
            DRAIN:   if (l3) state_nx = OUT;
            OUT:     if (out_ready) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

endmodule

// File: tb/tb_elm_neuron_mac_lanes.sv
// Bench for elm_neuron_mac_lanes: scoreboard of expected results
// against an independent integer model of the neuron.
module tb_elm_neuron_mac_lanes;

    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int NW   = 8;
    localparam int LN   = 2;
    localparam int NB   = NW / LN;
    localparam int CFGW = 2*DW+1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CFGW-1:0] cfg_layer, cfg_neuron;
    logic            wt_valid, bias_valid, in_valid, in_ready;
    logic [DW-1:0]   wt_data, bias_data, out_data;
    logic [1:0]      act_mode;
    logic [LN*DW-1:0] in_data;
    logic            out_valid, out_ready, out_sat;

    int n_chk  = 0;
    int n_fail = 0;

    logic [16:0]   sb_q [$];
    logic [16:0]   sb_e;
    logic [DW-1:0] wmodel [NW];
    logic [DW-1:0] wload  [NW];
    logic [DW-1:0] xin    [NW];
    logic [DW-1:0] bmodel;

    always #5 clk = ~clk;

    elm_neuron_mac_lanes #(
        .LAYER_NO(1), .NEURON_NO(0), .DW(DW), .FW(FW),
        .NUM_WEIGHT(NW), .LANES(LN), .CFGW(CFGW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .wt_valid(wt_valid), .wt_data(wt_data),
        .bias_valid(bias_valid), .bias_data(bias_data),
        .act_mode(act_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [1:0] mode);
        longint s, r, h;
        s = longint'($signed(bmodel)) * 256;
        for (int i = 0; i < NW; i++)
            s += longint'($signed(wmodel[i])) * longint'($signed(xin[i]));
        r = s >>> FW;
        if (mode == 2'd2) begin
            h = (r >>> 2) + 128;
            if (h < 0) h = 0;
            if (h > 256) h = 256;
            return {1'b0, h[15:0]};
        end
        if (mode == 2'd1 && r < 0) r = 0;
        if (r > 32767) return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    // scoreboard compare on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hdead);
            end else begin
                sb_e = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(sb_e[15:0]));
                check("out_sat", 32'(out_sat), 32'(sb_e[16]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_w(input logic [DW-1:0] v);
        for (int i = 0; i < NW; i++) wload[i] = v;
    endtask

    task automatic fill_x(input logic [DW-1:0] v);
        for (int i = 0; i < NW; i++) xin[i] = v;
    endtask

    task automatic load_weights(input int neuron);
        cfg_neuron = CFGW'(neuron);
        for (int i = 0; i < NW; i++) begin
            wt_valid = 1'b1;
            wt_data  = wload[i];
            tick(1);
        end
        wt_valid   = 1'b0;
        cfg_neuron = '0;
        if (neuron == 0)
            for (int i = 0; i < NW; i++) wmodel[i] = wload[i];
    endtask

    task automatic load_bias(input logic [DW-1:0] b);
        bias_valid = 1'b1;
        bias_data  = b;
        tick(1);
        bias_valid = 1'b0;
        bmodel     = b;
    endtask

    task automatic send_beat(input int b);
        int t;
        t = 0;
        in_valid = 1'b1;
        for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = xin[b*LN+k];
        while (!in_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic run(input int gap);
        sb_q.push_back(model(act_mode));
        for (int b = 0; b < NB; b++) begin
            send_beat(b);
            if (gap > 0) tick(gap);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            tick(1);
            t++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic seen;
        cfg_layer  = CFGW'(1);
        cfg_neuron = '0;
        wt_valid   = 1'b0;
        wt_data    = '0;
        bias_valid = 1'b0;
        bias_data  = '0;
        act_mode   = 2'd0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        bmodel     = '0;
        rst        = 1'b1;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick(1);

        // pass mode with latency check
        fill_w(16'h0100);
        load_weights(0);
        load_bias(16'h0080);
        fill_x(16'h0100);
        act_mode = 2'd0;
        run(0);
        check("drain_in_ready", 32'(in_ready), 32'd0);
        tick(2);
        check("lat_e2_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_e3_valid", 32'(out_valid), 32'd1);
        check("lat_e3_data", 32'(out_data), 32'h0880);
        drain();

        // ReLU and pass on negative sum
        fill_x(16'hFF00);
        load_bias(16'h0000);
        act_mode = 2'd1;
        run(0);
        drain();
        act_mode = 2'd0;
        run(0);
        drain();

        // hard-sigmoid: upper clamp, midpoint, lower clamp
        act_mode = 2'd2;
        fill_x(16'h0100);
        load_bias(16'h0080);
        run(0);
        drain();
        fill_x(16'h0000);
        load_bias(16'h0000);
        run(0);
        drain();
        fill_x(16'hFF00);
        run(0);
        drain();

        // output saturation both ways
        act_mode = 2'd0;
        fill_w(16'h7FFF);
        load_weights(0);
        fill_x(16'h7FFF);
        run(0);
        drain();
        fill_x(16'h8000);
        run(0);
        drain();

        // gaps between beats
        fill_w(16'h0100);
        load_weights(0);
        load_bias(16'h0010);
        for (int i = 0; i < NW; i++) xin[i] = DW'(i * 64 - 100);
        run(3);
        drain();

        // downstream stall with ignored weight writes
        out_ready = 1'b0;
        run(0);
        t = 0;
        while (!out_valid && t < 20) begin
            tick(1);
            t++;
        end
        check("stall_valid", 32'(out_valid), 32'd1);
        cfg_neuron = '0;
        for (int c = 0; c < 5; c++) begin
            wt_valid = 1'b1;
            wt_data  = 16'h0200;
            tick(1);
            check("stall_data", 32'(out_data), 32'(sb_q[0][15:0]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        wt_valid  = 1'b0;
        out_ready = 1'b1;
        tick(1);
        check("hs_next_in_ready", 32'(in_ready), 32'd1);
        run(0);
        drain();

        // writes to another neuron are ignored
        fill_w(16'h0300);
        load_weights(5);
        run(0);
        drain();

        // reset mid-vector abandons the run
        load_bias(16'h0040);
        send_beat(0);
        send_beat(1);
        rst = 1'b1;
        tick(1);
        rst    = 1'b0;
        bmodel = '0;
        seen   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (out_valid) seen = 1'b1;
        end
        check("rst_mid_no_valid", 32'(seen), 32'd0);
        run(0);
        drain();

        // random vectors, modes and bias
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NW; i++) wload[i] = DW'($urandom_range(0, 16'hFFFF));
            load_weights(0);
            load_bias(DW'($urandom_range(0, 16'hFFFF)));
            for (int i = 0; i < NW; i++) xin[i] = DW'($urandom_range(0, 16'hFFFF));
            act_mode = 2'($urandom_range(0, 3));
            run(n % 2);
            drain();
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
